fp_add_pipe_ctrl: RTL and testbench

- Sequencing controller for the pipelined floating-point adder datapath.
- Accepts operand tokens through a valid/ready handshake and tracks token validity through every pipeline stage.
- Generates per-stage enables and a global stall.
- Derives the operand bit-inversion controls for the alignment/inversion stage, delayed so they line up with the token occupying that stage.
- Sits between the adder's issue interface and its stage registers; it holds no datapath bits.

---
 rtl/fp_add_pipe_ctrl.sv | 145 ++++++++++++++
 tb/tb_fp_add_pipe_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_pipe_ctrl.sv
// fp_add_pipe_ctrl: sequencing controller for the pipelined FP adder.
// Tracks token validity, tags and operand-inversion controls through a
// stall-all pipeline of STAGES register stages. It holds no datapath bits.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         issue handshake (in_ready is combinational)
//   in_op_sub, in_sign_x/y,   operation and operand info used to derive
//   in_x_smaller              the inversion controls at accept
//   in_tag                    opaque token tag
//   flush                     drop all in-flight tokens
//   stage_en                  per-stage load enables (all equal: stall-all)
//   bit_inv_cont_x/y          invert controls for stage INV_STAGE
//   out_valid/out_ready       result handshake, out_tag result tag
//   occupancy, busy           in-flight token count / non-empty flag
//   perf_stall_cnt            (FP_ADD_PIPE_CTRL_PERF_EN only) saturating
//                             count of cycles with out_valid & !out_ready
//
// Optional feature macro: FP_ADD_PIPE_CTRL_PERF_EN
module fp_add_pipe_ctrl #(
  parameter int unsigned STAGES    = 8,
  parameter int unsigned INV_STAGE = 7,
  parameter int unsigned TAG_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_op_sub,
  input  logic              in_sign_x,
  input  logic              in_sign_y,
  input  logic              in_x_smaller,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic [STAGES-1:0] stage_en,
  output logic              bit_inv_cont_x,
  output logic              bit_inv_cont_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [4:0]        occupancy,
  output logic              busy
`ifdef FP_ADD_PIPE_CTRL_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt
`endif
);

  localparam int unsigned OCC_W  = 5;
  localparam int unsigned PERF_W = 16;

  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0]            invx_q, invx_d;
  logic [STAGES-1:0]            invy_q, invy_d;
  logic [STAGES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [OCC_W-1:0]             occ_q, occ_d;

  logic advance;
  logic accept;
  logic retire;
  logic eff_sub;

  // Handshake decode, pipeline shift and occupancy update.
  always_comb begin
    advance = !vld_q[STAGES-1] | out_ready;
    // A token offered during flush is dropped even though in_ready may be 1.
    accept  = in_valid & advance & !flush;
    retire  = vld_q[STAGES-1] & out_ready;
    eff_sub = in_sign_x ^ in_sign_y ^ in_op_sub;

    vld_d  = vld_q;
    invx_d = invx_q;
    invy_d = invy_q;
    tag_d  = tag_q;
    occ_d  = occ_q;

    if (flush) begin
      vld_d = '0;
      occ_d = '0;
    end else if (advance) begin
      vld_d  = {vld_q[STAGES-2:0], accept};
      invx_d = {invx_q[STAGES-2:0], eff_sub & in_x_smaller};
      invy_d = {invy_q[STAGES-2:0], eff_sub & !in_x_smaller};
      tag_d  = {tag_q[STAGES-2:0], in_tag};
      // retire implies advance, so both cases live under this branch.
      unique case ({accept, retire})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      invx_q <= '0;
      invy_q <= '0;
      tag_q  <= '0;
      occ_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      invx_q <= invx_d;
      invy_q <= invy_d;
      tag_q  <= tag_d;
      occ_q  <= occ_d;
    end
  end

`ifdef FP_ADD_PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_q, perf_d;

  // Saturating count of output back-pressure cycles.
  always_comb begin
    perf_d = perf_q;
    if (flush) begin
      perf_d = '0;
    end else if (vld_q[STAGES-1] && !out_ready && (perf_q != '1)) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;
`endif

  // Stored controls and tags of empty stages are gated off the outputs.
  assign in_ready       = advance;
  assign stage_en       = {STAGES{advance}};
  assign out_valid      = vld_q[STAGES-1];
  assign out_tag        = vld_q[STAGES-1] ? tag_q[STAGES-1] : '0;
  assign bit_inv_cont_x = invx_q[INV_STAGE-1] & vld_q[INV_STAGE-1];
  assign bit_inv_cont_y = invy_q[INV_STAGE-1] & vld_q[INV_STAGE-1];
  assign occupancy      = occ_q;
  assign busy           = |occ_q;

endmodule

// File: tb/tb_fp_add_pipe_ctrl.sv
// Self-checking bench for fp_add_pipe_ctrl (STAGES=8, INV_STAGE=7, TAG_W=4).
// Each cycle body runs at the falling edge: drive inputs, settle, compare.
module tb_fp_add_pipe_ctrl;

  localparam int unsigned STAGES = 8;
  localparam int unsigned TAG_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_op_sub;
  logic              in_sign_x;
  logic              in_sign_y;
  logic              in_x_smaller;
  logic [TAG_W-1:0]  in_tag;
  logic              flush;
  logic [STAGES-1:0] stage_en;
  logic              bit_inv_cont_x;
  logic              bit_inv_cont_y;
  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_tag;
  logic [4:0]        occupancy;
  logic              busy;
`ifdef FP_ADD_PIPE_CTRL_PERF_EN
  logic [15:0]       perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp_add_pipe_ctrl #(.STAGES(8), .INV_STAGE(7), .TAG_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op_sub      (in_op_sub),
    .in_sign_x      (in_sign_x),
    .in_sign_y      (in_sign_y),
    .in_x_smaller   (in_x_smaller),
    .in_tag         (in_tag),
    .flush          (flush),
    .stage_en       (stage_en),
    .bit_inv_cont_x (bit_inv_cont_x),
    .bit_inv_cont_y (bit_inv_cont_y),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_tag        (out_tag),
    .occupancy      (occupancy),
    .busy           (busy)
`ifdef FP_ADD_PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct {
    logic             sx;
    logic             sy;
    logic             op;
    logic             xs;
    logic [TAG_W-1:0] tag;
    logic             ex;
    logic             ey;
  } inv_vec_t;

  inv_vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic set_ops(input logic sx, input logic sy, input logic op, input logic xs);
    in_sign_x = sx; in_sign_y = sy; in_op_sub = op; in_x_smaller = xs;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_tag = '0;
    set_ops(1'b0, 1'b0, 1'b0, 1'b0);

    // sign_x, sign_y, op_sub, x_smaller, tag, expected inv_x, inv_y
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hC, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h6, 1'b1, 1'b0};

    // Reset state.
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_inv_x", 32'(bit_inv_cont_x), 32'd0);
    chk("rst_inv_y", 32'(bit_inv_cont_y), 32'd0);
    chk("rst_stage_en", 32'(stage_en), 32'hFF);
    out_ready = 1'b0;
    #1;
    chk("empty_in_ready_no_out_ready", 32'(in_ready), 32'd1);
    chk("empty_stage_en_no_out_ready", 32'(stage_en), 32'hFF);

    // Single-token latency and inversion controls, table driven.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        in_valid  = (c == 0);
        set_ops(vecs[v].sx, vecs[v].sy, vecs[v].op, vecs[v].xs);
        in_tag    = vecs[v].tag;
        out_ready = 1'b1;
        #1;
        if (c == 0) chk("single_in_ready", 32'(in_ready), 32'd1);
        chk($sformatf("v%0d_inv_x_c%0d", v, c), 32'(bit_inv_cont_x), (c == 7) ? 32'(vecs[v].ex) : 32'd0);
        chk($sformatf("v%0d_inv_y_c%0d", v, c), 32'(bit_inv_cont_y), (c == 7) ? 32'(vecs[v].ey) : 32'd0);
        chk($sformatf("v%0d_out_valid_c%0d", v, c), 32'(out_valid), (c == 8) ? 32'd1 : 32'd0);
        if (c == 8) chk($sformatf("v%0d_out_tag", v), 32'(out_tag), 32'(vecs[v].tag));
      end
    end
    in_valid = 1'b0;

    // Back-to-back issue, full throughput.
    do_reset();
    set_ops(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      in_valid  = (c < 8);
      in_tag    = TAG_W'(c);
      out_ready = 1'b1;
      #1;
      if (c < 8) chk($sformatf("b2b_in_ready_c%0d", c), 32'(in_ready), 32'd1);
      if (c >= 8) chk($sformatf("b2b_out_valid_c%0d", c), 32'(out_valid), (c < 16) ? 32'd1 : 32'd0);
      if (c >= 8 && c < 16) chk($sformatf("b2b_out_tag_c%0d", c), 32'(out_tag), 32'(c - 8));
    end

    // Fill under back-pressure, then simultaneous retire and accept.
    do_reset();
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      out_ready = (c >= 13);
      in_valid  = (c <= 13);
      in_tag    = (c == 13) ? 4'hE : TAG_W'(c);
      #1;
      if (c < 8) chk($sformatf("fill_in_ready_c%0d", c), 32'(in_ready), 32'd1);
      if (c >= 8 && c <= 12) begin
        chk($sformatf("stall_in_ready_c%0d", c), 32'(in_ready), 32'd0);
        chk($sformatf("stall_occupancy_c%0d", c), 32'(occupancy), 32'd8);
        chk($sformatf("stall_out_valid_c%0d", c), 32'(out_valid), 32'd1);
        chk($sformatf("stall_out_tag_c%0d", c), 32'(out_tag), 32'd0);
        chk($sformatf("stall_stage_en_c%0d", c), 32'(stage_en), 32'd0);
      end
      if (c == 13) begin
        chk("full_in_ready", 32'(in_ready), 32'd1);
        chk("full_occupancy", 32'(occupancy), 32'd8);
`ifdef FP_ADD_PIPE_CTRL_PERF_EN
        chk("perf_stall_cnt", 32'(perf_stall_cnt), 32'd5);
`endif
      end
      if (c == 14) chk("swap_occupancy", 32'(occupancy), 32'd8);
      if (c >= 14 && c <= 20) chk($sformatf("drain_out_tag_c%0d", c), 32'(out_tag), 32'(c - 13));
      if (c == 21) begin
        chk("late_token_valid", 32'(out_valid), 32'd1);
        chk("late_token_tag", 32'(out_tag), 32'hE);
        chk("late_occupancy", 32'(occupancy), 32'd1);
      end
      if (c == 22) begin
        chk("drained_occupancy", 32'(occupancy), 32'd0);
        chk("drained_out_valid", 32'(out_valid), 32'd0);
      end
    end

    // Flush with four tokens in flight and a token offered in the flush cycle.
    do_reset();
    set_ops(1'b0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      in_valid  = (c <= 4);
      in_tag    = (c == 4) ? 4'hF : TAG_W'(c + 1);
      flush     = (c == 4);
      out_ready = 1'b1;
      #1;
      if (c == 4) chk("pre_flush_occupancy", 32'(occupancy), 32'd4);
      if (c == 5) begin
        chk("flush_occupancy", 32'(occupancy), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
      end
      if (c >= 5) begin
        chk($sformatf("flush_out_valid_c%0d", c), 32'(out_valid), 32'd0);
        chk($sformatf("flush_out_tag_c%0d", c), 32'(out_tag), 32'd0);
        chk($sformatf("flush_inv_x_c%0d", c), 32'(bit_inv_cont_x), 32'd0);
        chk($sformatf("flush_inv_y_c%0d", c), 32'(bit_inv_cont_y), 32'd0);
      end
    end
    flush = 1'b0;

    // Reset while three tokens are in flight and the output is stalled.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      in_valid  = (c < 3);
      in_tag    = TAG_W'(c + 3);
      out_ready = 1'b0;
      rst       = (c == 9);
      #1;
      if (c == 9) begin
        chk("pre_rst_stage_en", 32'(stage_en), 32'd0);
        chk("pre_rst_occupancy", 32'(occupancy), 32'd3);
`ifdef FP_ADD_PIPE_CTRL_PERF_EN
        chk("pre_rst_perf", 32'(perf_stall_cnt), 32'd1);
`endif
      end
      if (c == 10) begin
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_tag", 32'(out_tag), 32'd0);
        chk("mid_rst_occupancy", 32'(occupancy), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_inv_x", 32'(bit_inv_cont_x), 32'd0);
        chk("mid_rst_inv_y", 32'(bit_inv_cont_y), 32'd0);
        chk("mid_rst_stage_en", 32'(stage_en), 32'hFF);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef FP_ADD_PIPE_CTRL_PERF_EN
        chk("mid_rst_perf", 32'(perf_stall_cnt), 32'd0);
`endif
      end
      if (c > 10) chk($sformatf("post_rst_out_valid_c%0d", c), 32'(out_valid), 32'd0);
    end
    out_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
